bm_result_fifo: RTL and testbench
=================================

Name: bm_result_fifo

Overview:
- Downstream capture stage for the registered 32-bit operand microbenchmark.
- Accepts that stage's result word (out0) and 1-bit flag (out1) each cycle they are marked valid, and buffers them in a small register FIFO.
- Drains the buffered results to a consumer over a valid/ready handshake.
- Counts results that arrive while the FIFO is full and cannot be accepted.

Parameters:
- BITS, 32, data width; matches the upstream operand/result width.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- ADDR_BITS, 3, log2(DEPTH).
- DROP_BITS, 16, width of the saturating drop counter.

Ports:
- clock  input  1  rising-edge clock, single domain.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result is valid this cycle.
- in_data  input  BITS  upstream result word (out0).
- in_flag  input  1  upstream result flag (out1).
- in_ready  output  1  FIFO can accept a push this cycle.
- flush  input  1  synchronous clear of FIFO contents and drop counter.
- out_valid  output  1  head entry is available.
- out_data  output  BITS  head entry data.
- out_flag  output  1  head entry flag.
- out_ready  input  1  consumer takes the head entry this cycle.
- level  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- drop_count  output  DROP_BITS  number of valid inputs lost while full.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - All state clears immediately on reset_n low, independent of clock.
  - Reset values: wr_ptr=0, rd_ptr=0, level=0, drop_count=0, out_valid=0, in_ready=1, out_data=0, out_flag=0.
  - Memory array contents are not reset.
  - Reset asserted mid-stream discards all buffered entries; no partial pop occurs.
- Storage:
  - DEPTH x (BITS+1) register array; each entry holds {flag, data}.
  - Pointers are ADDR_BITS wide and wrap naturally from DEPTH-1 to 0.
  - level is an explicit counter, not derived from the pointers.
- Push and pop conditions:
  - pop = out_valid & out_ready.
  - push = in_valid & in_ready.
  - in_ready = (level != DEPTH) | out_ready. A full FIFO accepts a push in the same cycle as a pop (pass-through, no bubble).
  - Show-ahead: out_valid = (level != 0); out_data/out_flag = mem[rd_ptr], combinational from the register array.
  - When empty, out_data/out_flag are don't-care, but must not be X after reset; drive them to zero when level == 0.
- Latency:
  - A push at edge N makes the entry visible on out_* in the cycle after edge N.
  - There is no combinational path from in_* to out_*.
- Occupancy update each edge:
  - push only: level+1.
  - pop only: level-1.
  - both or neither: unchanged.
- Drop counting:
  - drop = in_valid & ~in_ready.
  - drop_count increments by 1 per drop and saturates at all-ones; it never wraps.
- Flush (synchronous, highest priority below reset):
  - On an edge with flush=1: pointers, level and drop_count clear to 0.
  - Any push, pop or drop in that same cycle is ignored.
  - out_valid reads 0 in the following cycle.
- Invariants:
  - level never exceeds DEPTH and never underflows.
  - A pop with out_valid=0 is impossible by construction.

Decomposition:
- Shared Verilog include file holds the widths: BITS, DEPTH, ADDR_BITS, DROP_BITS. The same file is included by the upstream AND stage so both agree on BITS.
- One natural sub-module: bm_fifo_regfile.
  - Synchronous write port: we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
  - Width BITS+1, no reset.
- bm_result_fifo keeps pointers, level, handshake logic and the drop counter.

Test Plan:
- Reset then idle, in_valid=0 for 5 cycles -> out_valid=0, level=0, in_ready=1, drop_count=0, out_data=0.
- Push 0xA5A5A5A5/flag 1, then 0x0000FFFF/flag 0, with out_ready=0 -> level=2. Raising out_ready then yields 0xA5A5A5A5/1 followed by 0x0000FFFF/0, and out_valid falls after the second pop.
- Push 8 words 0x1..0x8 with out_ready=0 -> level=8, in_ready=0. Three further valid inputs -> drop_count=3 and contents unchanged. Draining returns 0x1..0x8 in order, confirming pointer wrap on a second fill of 0x9..0x10.
- Full FIFO with in_valid=1 and out_ready=1 held for 10 cycles -> level stays 8, no drops, output sequence continuous with no bubble.
- Assert flush with level=5 and drop_count=2 -> next cycle level=0, out_valid=0, drop_count=0. A push of 0xDEADBEEF in the flush cycle is not stored.
- Pulse reset_n low asynchronously mid-cycle with level=4 -> outputs clear before the next clock edge. After release, the first new push 0x12345678 is the first word out.
- Hold in_valid=1 with out_ready=0 for 2^16+10 cycles -> drop_count saturates at 0xFFFF.

Source files
------------

// File: rtl/bm_result_fifo_pkg.sv
// Shared widths and helpers for the result-capture FIFO. The upstream
// operand/result stage imports the same package so both agree on BITS.
package bm_result_fifo_pkg;

  localparam int BITS      = 32;
  localparam int DEPTH     = 8;
  localparam int ADDR_BITS = 3;
  localparam int DROP_BITS = 16;

  // Occupancy value that means "every entry is used".
  localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);

  // One stored result: flag in the MSB, data word below it.
  typedef struct packed {
    logic            flag;
    logic [BITS-1:0] data;
  } entry_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_BITS-1:0] sat_inc(input logic [DROP_BITS-1:0] v);
    if (v == {DROP_BITS{1'b1}}) begin
      return v;
    end else begin
      return v + DROP_BITS'(1);
    end
  endfunction

endpackage

// File: rtl/bm_fifo_regfile.sv
// Register array for the result FIFO: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module bm_fifo_regfile #(
  parameter int W  = 33,
  parameter int AW = 3
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [2**AW];

  // Capture the write data into the addressed entry.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bm_result_fifo.sv
// Capture FIFO for the microbenchmark result stream. Buffers {flag, data}
// pairs, drains them show-ahead over valid/ready, and counts inputs lost
// while full. A full FIFO still accepts a push when the head is popped in
// the same cycle, so a continuous stream flows with no bubble.
module bm_result_fifo
  import bm_result_fifo_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [BITS-1:0]      in_data,
  input  logic                 in_flag,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [BITS-1:0]      out_data,
  output logic                 out_flag,
  input  logic                 out_ready,
  output logic [ADDR_BITS:0]   level,
  output logic [DROP_BITS-1:0] drop_count
);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic [DROP_BITS-1:0] drop_q, drop_d;

  logic   in_ready_s;
  logic   out_valid_s;
  logic   push_s;
  logic   pop_s;
  logic   drop_s;
  logic   we_s;
  entry_t wentry_s;
  entry_t rentry_s;

  // Handshake qualifiers derived from the occupancy counter.
  always_comb begin
    out_valid_s = (level_q != '0);
    in_ready_s  = (level_q != FULL_LEVEL) | out_ready;
    push_s      = in_valid & in_ready_s;
    pop_s       = out_valid_s & out_ready;
    drop_s      = in_valid & ~in_ready_s;
    // Flush discards the push of its own cycle, so nothing is written.
    we_s        = push_s & ~flush;
  end

  // Next pointers, occupancy and drop count; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + (ADDR_BITS + 1)'(1);
        2'b01:   level_d = level_q - (ADDR_BITS + 1)'(1);
        default: level_d = level_q;
      endcase
      if (drop_s) begin
        drop_d = sat_inc(drop_q);
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Pack the incoming result into one storage word.
  always_comb begin
    wentry_s.flag = in_flag;
    wentry_s.data = in_data;
  end

  bm_fifo_regfile #(
    .W  (BITS + 1),
    .AW (ADDR_BITS)
  ) u_regfile (
    .clock (clock),
    .we    (we_s),
    .waddr (wr_ptr_q),
    .wdata (wentry_s),
    .raddr (rd_ptr_q),
    .rdata (rentry_s)
  );

  // Show-ahead head word, forced to zero when empty so it is never X.
  always_comb begin
    if (out_valid_s) begin
      out_data = rentry_s.data;
      out_flag = rentry_s.flag;
    end else begin
      out_data = '0;
      out_flag = 1'b0;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign level      = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_bm_result_fifo.sv
module tb_bm_result_fifo;
  import bm_result_fifo_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic [BITS-1:0]      in_data;
  logic                 in_flag;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic [BITS-1:0]      out_data;
  logic                 out_flag;
  logic                 out_ready;
  logic [ADDR_BITS:0]   level;
  logic [DROP_BITS-1:0] drop_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a queue of {flag, data} plus a saturating drop tally.
  logic [32:0] mq[$];
  int unsigned mdrop;

  always #5 clock = ~clock;

  bm_result_fifo dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_flag    (in_flag),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_flag   (out_flag),
    .out_ready  (out_ready),
    .level      (level),
    .drop_count (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic f,
                       input logic r, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_flag   = f;
    out_ready = r;
    flush     = fl;
  endtask

  // Compare every output with what the queue model predicts right now.
  task automatic check_all(input string tag);
    logic [31:0] ed;
    logic        ef;
    ed = 32'h0;
    ef = 1'b0;
    if (mq.size() != 0) begin
      ed = mq[0][31:0];
      ef = mq[0][32];
    end
    chk({tag, ".level"},  64'(level), 64'(mq.size()));
    chk({tag, ".valid"},  64'(out_valid), 64'(mq.size() != 0));
    chk({tag, ".ready"},  64'(in_ready), 64'((mq.size() != DEPTH) || out_ready));
    chk({tag, ".data"},   64'(out_data), 64'(ed));
    chk({tag, ".flag"},   64'(out_flag), 64'(ef));
    chk({tag, ".drops"},  64'(drop_count), 64'(mdrop));
  endtask

  // One clock: check, decide model action from the rules, step, update.
  task automatic tick(input string tag);
    bit m_ready, m_push, m_pop, m_drop;
    #1;
    check_all(tag);
    m_ready = (mq.size() != DEPTH) || out_ready;
    m_push  = in_valid && m_ready;
    m_pop   = (mq.size() != 0) && out_ready;
    m_drop  = in_valid && !m_ready;
    @(posedge clock);
    #1;
    if (flush) begin
      mq.delete();
      mdrop = 0;
    end else begin
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back({in_flag, in_data});
      if (m_drop && mdrop < 32'hFFFF) mdrop++;
    end
  endtask

  initial begin
    mdrop = 0;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) tick("idle");
    chk("idle.data0", 64'(out_data), 64'h0);

    // Two pushes held, then drained in order.
    drive(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0); tick("p2a");
    drive(1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0); tick("p2b");
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("p2.level", 64'(level), 64'd2);
    chk("p2.head",  64'({out_flag, out_data}), 64'h1A5A5A5A5);
    tick("pop1");
    chk("p2.second", 64'({out_flag, out_data}), 64'h00000FFFF);
    tick("pop2");
    chk("p2.empty", 64'(out_valid), 64'd0);

    // Fill, overflow, drain; second fill exercises pointer wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 1; i <= 8; i++) begin
        drive(1'b1, 32'(pass * 8 + i), 1'(i), 1'b0, 1'b0);
        tick("fill");
      end
      #1;
      chk("full.level", 64'(level), 64'd8);
      chk("full.ready", 64'(in_ready), 64'd0);
      if (pass == 0) begin
        for (int i = 0; i < 3; i++) begin
          drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
          tick("ovf");
        end
        #1;
        chk("ovf.drops", 64'(drop_count), 64'd3);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
        #1;
        chk("drain.data", 64'(out_data), 64'(pass * 8 + i));
        tick("drain");
      end
    end

    // Full with simultaneous push and pop: no bubble, no drops.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick("pf");
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h40 + 32'(i), 1'b1, 1'b1, 1'b0);
      #1;
      chk("pass.level", 64'(level), 64'd8);
      chk("pass.valid", 64'(out_valid), 64'd1);
      chk("pass.data",  64'(out_data), (i < 8) ? 64'(32'h20 + 32'(i)) : 64'(32'h40 + 32'(i - 8)));
      tick("pass");
    end
    chk("pass.drops", 64'(drop_count), 64'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick("pdrain");

    // Flush with level 5 and two new drops; same-cycle push is lost.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1); tick("preflush");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick("ffill");
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick("fpop");
    #1;
    chk("fl.level5", 64'(level), 64'd5);
    chk("fl.drop2",  64'(drop_count), 64'd2);
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1); tick("flush");
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fl.level", 64'(level), 64'd0);
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.drops", 64'(drop_count), 64'd0);
    tick("postflush");

    // Asynchronous reset in the middle of a cycle with four entries held.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick("rfill");
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar.level", 64'(level), 64'd0);
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.ready", 64'(in_ready), 64'd1);
    chk("ar.data",  64'(out_data), 64'd0);
    mq.delete();
    mdrop = 0;
    #1;
    reset_n = 1'b1;
    drive(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0); tick("arpush");
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("ar.first", 64'(out_data), 64'h12345678);
    tick("arpop");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
      tick("rand");
    end

    // Saturation of the drop counter.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1); tick("satclr");
    drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65536 + 10; i++) tick("sat");
    #1;
    chk("sat.drops", 64'(drop_count), 64'hFFFF);
    chk("sat.level", 64'(level), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
